tlp_tx_arbiter: RTL and testbench
=================================

# tlp_tx_arbiter

Two-requester arbiter and sequencer for the PCIe endpoint's VC0 transmit TLP interface. It shares the single tx_req/tx_rdy/tx_data port between two TLP sources, such as a completion generator and an MSI/DMA writer. It runs the request/ready handshake, frames each TLP with start/end strobes, and nullifies TLPs that are malformed or interrupted by link loss. It sits between user logic and the endpoint core in the 125 MHz sys_clk_125 domain.

## Interface
Parameters:
- DATA_W, 16, TLP data word width (matches core tx_data_vc0)
- MAX_WORDS, 256, maximum words per TLP before forced termination
- RDY_TIMEOUT, 1024, cycles to wait for tx_rdy_vc0 before abandoning a request

Ports (reset rst, asynchronous, active-high; clock clk):
- clk  in  1  system clock (core sys_clk_125)
- rst  in  1  asynchronous active-high reset
- dl_up  in  1  data link layer up, from core
- rq_req[1:0]  in  2  per-requester TLP pending, level
- rq_data0, rq_data1  in  DATA_W  requester data words
- rq_valid[1:0]  in  2  requester word valid
- rq_end[1:0]  in  2  last word of TLP, qualified by valid
- rq_gnt[1:0]  out  2  one-hot grant, held for the whole TLP
- rq_ready[1:0]  out  2  word accepted this cycle when valid & ready
- tx_req_vc0  out  1  request to core
- tx_rdy_vc0  in  1  core ready
- tx_data_vc0  out  DATA_W  data to core
- tx_st_vc0  out  1  first word strobe
- tx_end_vc0  out  1  last word strobe
- tx_nlfy_vc0  out  1  nullify, asserted only together with tx_end_vc0
- err_timeout, err_overlen  out  1  single-cycle error pulses

## Operation
- States: IDLE, REQ, XFER.
- Reset: state IDLE. Outputs rq_gnt=0, rq_ready=0, tx_req_vc0=0, tx_st/end/nlfy=0, tx_data_vc0=0, err pulses 0. RR pointer is set so requester 0 wins the first tie.
- IDLE: if dl_up=1 and any rq_req is set, pick a winner, register rq_gnt, go to REQ. With one requester active, that requester wins. With both active, the one not served last wins. The pointer updates on grant.
- IDLE with dl_up=0: no grants.
- REQ: tx_req_vc0=1.
  - On tx_rdy_vc0=1, go to XFER. tx_req_vc0 drops the cycle XFER is entered.
  - If RDY_TIMEOUT cycles pass without tx_rdy, pulse err_timeout, clear grant, go to IDLE.
- XFER:
  - rq_ready[g] = tx_rdy_vc0 for the granted requester g; 0 for the other.
  - tx_data_vc0 = rq_data[g].
  - A word transfers when rq_valid[g] & tx_rdy_vc0.
  - tx_st_vc0 = transfer & first-word flag.
  - tx_end_vc0 = transfer & (rq_end[g] | word count = MAX_WORDS-1).
  - On tx_end_vc0, go to IDLE and clear grant.
- Requesters are required to present contiguous valid words once tx_rdy_vc0 is high. The arbiter does not pad gaps.
- Word counter: log2(MAX_WORDS) bits, reset on entry to XFER, incremented per transfer.
  - If the count reaches MAX_WORDS-1 without rq_end: force tx_end_vc0 and tx_nlfy_vc0 on that word and pulse err_overlen.
  - The requester sees rq_ready drop and its grant removed. Any remaining words are its responsibility to discard.
- dl_up falling:
  - In REQ: abandon like a timeout, but with no err pulse.
  - In XFER: the TLP continues to its end, and tx_nlfy_vc0 is asserted with tx_end_vc0. A sticky nullify flag is cleared on IDLE entry.
- A single-word TLP (valid & end on the first word) asserts tx_st_vc0 and tx_end_vc0 in the same cycle.
- rq_req dropping after grant is ignored until the TLP ends or is abandoned.

## Timing
- rq_req to rq_gnt: 1 cycle. rq_gnt to tx_req_vc0: same cycle (both registered on IDLE to REQ).
- tx_rdy_vc0 high in REQ: XFER next cycle. rq_ready is combinational from tx_rdy_vc0 in XFER.
- Core-side tx_data/st/end/nlfy are combinational from the requester mux and state. No pipeline latency on data.
- After tx_end_vc0, one IDLE cycle before the next grant. Back-to-back TLP spacing is at least 2 cycles of request overhead.
- Reset mid-TLP: all outputs go to reset values immediately, asynchronously. No tx_end is emitted.

## Test plan
- Single requester: rq_req[0] with a 4-word TLP 0x1111..0x4444, tx_rdy_vc0 asserted 3 cycles after tx_req_vc0 → tx_st on 0x1111, tx_end on 0x4444, nlfy=0, tx_req low in XFER.
- Contention: both rq_req held for 4 TLPs of 2 words → grants alternate 0,1,0,1. The first grant goes to requester 0.
- Timeout: RDY_TIMEOUT=8, tx_rdy_vc0 held low → err_timeout pulses on cycle 8 of REQ, grant clears, tx_req_vc0=0.
- Overlength: MAX_WORDS=4, 6-word TLP with no end before word 6 → tx_end and tx_nlfy on word 4, err_overlen pulses once, rq_ready[0]=0 after.
- Link drop: dl_up falls on word 2 of a 5-word TLP → words 3–5 still pass, tx_nlfy_vc0=1 with tx_end on word 5. No new grant while dl_up=0.
- Reset mid-XFER: rst asserted on word 2 → tx_st/end/req/gnt=0 at once. After release, requester 0 wins the first tie.

Source files
------------

// File: rtl/tlp_tx_arbiter_if.sv
// tlp_tx_arbiter_if
// Bundles every non-clock signal of the VC0 transmit arbiter.
//   slave  : the arbiter itself. Inputs are the link status, the requester
//            side and the core ready. Outputs are grants, readies, the core
//            side and the error pulses.
//   master : the surrounding logic, i.e. the requesters plus the endpoint
//            core. It is the mirror image of slave.
// state_dbg carries the arbiter FSM state for observation.
interface tlp_tx_arbiter_if #(
  parameter int DATA_W = 16
);
  logic              dl_up;
  logic [1:0]        rq_req;
  logic [DATA_W-1:0] rq_data0;
  logic [DATA_W-1:0] rq_data1;
  logic [1:0]        rq_valid;
  logic [1:0]        rq_end;
  logic [1:0]        rq_gnt;
  logic [1:0]        rq_ready;
  logic              tx_req_vc0;
  logic              tx_rdy_vc0;
  logic [DATA_W-1:0] tx_data_vc0;
  logic              tx_st_vc0;
  logic              tx_end_vc0;
  logic              tx_nlfy_vc0;
  logic              err_timeout;
  logic              err_overlen;
  logic [1:0]        state_dbg;

  modport slave (
    input  dl_up, rq_req, rq_data0, rq_data1, rq_valid, rq_end, tx_rdy_vc0,
    output rq_gnt, rq_ready, tx_req_vc0, tx_data_vc0, tx_st_vc0, tx_end_vc0,
           tx_nlfy_vc0, err_timeout, err_overlen, state_dbg
  );

  modport master (
    output dl_up, rq_req, rq_data0, rq_data1, rq_valid, rq_end, tx_rdy_vc0,
    input  rq_gnt, rq_ready, tx_req_vc0, tx_data_vc0, tx_st_vc0, tx_end_vc0,
           tx_nlfy_vc0, err_timeout, err_overlen, state_dbg
  );
endinterface

// File: rtl/tlp_tx_arbiter.sv
// tlp_tx_arbiter
// Two-requester round-robin arbiter and sequencer for the VC0 transmit TLP
// port of the PCIe endpoint core (sys_clk_125 domain).
// Ports:
//   clk  system clock
//   rst  asynchronous, active-high reset
//   bus  tlp_tx_arbiter_if.slave: requester side (rq_*), core side (tx_*),
//        dl_up, error pulses (err_timeout, err_overlen), state_dbg
//
// Handshake semantics:
//   - A requester word moves on any cycle where rq_valid[g] & rq_ready[g] is
//     true. rq_ready[g] equals tx_rdy_vc0 while in XFER, so every accepted
//     word is also a word presented to the core on that same cycle.
//   - tx_st/end/nlfy_vc0 are meaningful only on such transfer cycles.
//     tx_nlfy_vc0 is never high without tx_end_vc0.
module tlp_tx_arbiter #(
  parameter int DATA_W      = 16,
  parameter int MAX_WORDS   = 256,
  parameter int RDY_TIMEOUT = 1024
) (
  input logic            clk,
  input logic            rst,
  tlp_tx_arbiter_if.slave bus
);
  localparam int CNT_W = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam int TMR_W = $clog2(RDY_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WORDS - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(RDY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_XFER = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         gnt_q, gnt_d;
  logic               last_q, last_d;  // index of the requester served last
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               nlfy_q, nlfy_d;  // link dropped during this TLP

  logic              sel;
  logic              in_xfer;
  logic              sel_valid;
  logic              sel_end;
  logic [DATA_W-1:0] sel_data;
  logic              xfer_word;
  logic              at_last;
  logic              force_end;
  logic              tx_end;
  logic              win;

  // Requester-side mux. The grant is one-hot, so bit 1 selects the source.
  assign sel       = gnt_q[1];
  assign in_xfer   = (state_q == S_XFER);
  assign sel_valid = sel ? bus.rq_valid[1] : bus.rq_valid[0];
  assign sel_end   = sel ? bus.rq_end[1]   : bus.rq_end[0];
  assign sel_data  = sel ? bus.rq_data1    : bus.rq_data0;

  assign xfer_word = in_xfer & sel_valid & bus.tx_rdy_vc0;
  assign at_last   = (cnt_q == CNT_LAST);
  // The last word the core may take without an end marker is cut short and
  // poisoned, so an over-long TLP never reaches the link intact.
  assign force_end = xfer_word & at_last & ~sel_end;
  assign tx_end    = xfer_word & (sel_end | at_last);

  assign bus.rq_gnt      = gnt_q;
  assign bus.rq_ready    = in_xfer ? (gnt_q & {2{bus.tx_rdy_vc0}}) : 2'b00;
  assign bus.tx_req_vc0  = (state_q == S_REQ);
  assign bus.tx_data_vc0 = in_xfer ? sel_data : '0;
  assign bus.tx_st_vc0   = xfer_word & (cnt_q == '0);
  assign bus.tx_end_vc0  = tx_end;
  // dl_up is also checked directly so a drop on the final word still poisons it.
  assign bus.tx_nlfy_vc0 = tx_end & (force_end | nlfy_q | ~bus.dl_up);
  assign bus.err_overlen = force_end;
  // A ready arriving on the final timer cycle still wins, and a link drop
  // abandons the request silently.
  assign bus.err_timeout = (state_q == S_REQ) & bus.dl_up & ~bus.tx_rdy_vc0 &
                           (tmr_q == TMR_LAST);
  assign bus.state_dbg   = state_q;

  // Round robin: with both requesting, the one not served last wins.
  assign win = (&bus.rq_req) ? ~last_q : bus.rq_req[1];

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    nlfy_d  = nlfy_q;
    case (state_q)
      S_IDLE: begin
        nlfy_d = 1'b0;
        if (bus.dl_up && (|bus.rq_req)) begin
          gnt_d   = win ? 2'b10 : 2'b01;
          last_d  = win;
          tmr_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (!bus.dl_up) begin
          gnt_d   = 2'b00;
          state_d = S_IDLE;
        end else if (bus.tx_rdy_vc0) begin
          cnt_d   = '0;
          nlfy_d  = 1'b0;
          state_d = S_XFER;
        end else if (tmr_q == TMR_LAST) begin
          gnt_d   = 2'b00;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_XFER: begin
        if (!bus.dl_up) nlfy_d = 1'b1;
        if (xfer_word) cnt_d = cnt_q + 1'b1;
        if (tx_end) begin
          gnt_d   = 2'b00;
          nlfy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        gnt_d   = 2'b00;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= 2'b00;
      last_q  <= 1'b1;  // requester 0 wins the first tie
      cnt_q   <= '0;
      tmr_q   <= '0;
      nlfy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      nlfy_q  <= nlfy_d;
    end
  end
endmodule

// File: tb/tb_tlp_tx_arbiter.sv
module tb_tlp_tx_arbiter;
  localparam int DW   = 16;
  localparam int MAXW = 8;
  localparam int TMO  = 8;
  localparam int PW   = 23;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   ovl_cnt;
  logic [PW-1:0] exp_q[$];

  tlp_tx_arbiter_if #(.DATA_W(DW)) bus ();

  tlp_tx_arbiter #(.DATA_W(DW), .MAX_WORDS(MAXW), .RDY_TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] pkt(input logic [1:0] g, input logic rq,
                                        input logic st, input logic en,
                                        input logic nl, input logic ov,
                                        input logic [DW-1:0] d);
    return {g, rq, st, en, nl, ov, d};
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && bus.err_overlen) ovl_cnt++;
  end

  always @(negedge clk) begin
    logic [PW-1:0] e;
    logic [PW-1:0] a;
    if (!rst && (|(bus.rq_ready & bus.rq_valid))) begin
      a = pkt(bus.rq_gnt, bus.tx_req_vc0, bus.tx_st_vc0, bus.tx_end_vc0,
              bus.tx_nlfy_vc0, bus.err_overlen, bus.tx_data_vc0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_word: got 0x%0h, expected no transfer at %0t", a, $time);
      end else begin
        e = exp_q.pop_front();
        chk("tx_word", 32'(a), 32'(e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_word(input int r, input logic [DW-1:0] d, input bit last);
    bus.rq_valid = 2'b01 << r;
    bus.rq_end   = last ? (2'b01 << r) : 2'b00;
    if (r == 0) bus.rq_data0 = d;
    else        bus.rq_data1 = d;
  endtask

  task automatic wait_gnt(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (|bus.rq_gnt) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL gnt_wait: got no grant, expected one within 20 cycles at %0t", $time);
    end
  endtask

  // One TLP from requester r with its end marker on word end_at. Words are
  // base + i*0x1111. A drop_at of 0 means the link stays up.
  task automatic run_tlp(input int r, input int end_at, input int rdy_delay,
                         input int drop_at, input bit keep_req, input logic [DW-1:0] base);
    bit ok;
    bit forced;
    int n_tx;
    logic [1:0] oh;
    logic [DW-1:0] d;
    oh     = 2'b01 << r;
    forced = (end_at > MAXW);
    n_tx   = forced ? MAXW : end_at;
    wait_gnt(ok);
    if (!ok) return;
    chk("grant", 32'(bus.rq_gnt), 32'(oh));
    chk("tx_req_in_req", 32'(bus.tx_req_vc0), 32'd1);
    if (!keep_req) bus.rq_req = 2'b00;
    repeat (rdy_delay) tick();
    bus.tx_rdy_vc0 = 1'b1;
    tick();
    for (int i = 1; i <= n_tx; i++) begin
      d = base + DW'(i * 32'h1111);
      exp_q.push_back(pkt(oh, 1'b0, i == 1, i == n_tx,
                          (i == n_tx) && (forced || drop_at != 0),
                          forced && (i == n_tx), d));
      drive_word(r, d, i == end_at);
      if (i == drop_at) bus.dl_up = 1'b0;
      tick();
    end
    if (forced) begin
      drive_word(r, base + DW'((n_tx + 1) * 32'h1111), 1'b0);
      #1;
      chk("ready_after_force", 32'(bus.rq_ready), 32'd0);
    end
    bus.rq_valid   = 2'b00;
    bus.rq_end     = 2'b00;
    bus.tx_rdy_vc0 = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit ok;
    n_checks = 0;
    n_fail   = 0;
    ovl_cnt  = 0;
    rst = 1'b1;
    bus.dl_up = 1'b1;
    bus.rq_req = 2'b00;
    bus.rq_data0 = '0;
    bus.rq_data1 = '0;
    bus.rq_valid = 2'b00;
    bus.rq_end = 2'b00;
    bus.tx_rdy_vc0 = 1'b0;
    #23;
    chk("rst_gnt",   32'(bus.rq_gnt), 32'd0);
    chk("rst_ready", 32'(bus.rq_ready), 32'd0);
    chk("rst_req",   32'(bus.tx_req_vc0), 32'd0);
    chk("rst_strb",  32'({bus.tx_st_vc0, bus.tx_end_vc0, bus.tx_nlfy_vc0}), 32'd0);
    chk("rst_data",  32'(bus.tx_data_vc0), 32'd0);
    chk("rst_err",   32'({bus.err_timeout, bus.err_overlen}), 32'd0);
    chk("rst_state", 32'(bus.state_dbg), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Contention: four 2-word TLPs, grants alternate starting with 0.
    bus.rq_req = 2'b11;
    run_tlp(0, 2, 1, 0, 1'b1, 16'h0100);
    run_tlp(1, 2, 1, 0, 1'b1, 16'h0200);
    run_tlp(0, 2, 1, 0, 1'b1, 16'h0300);
    run_tlp(1, 2, 1, 0, 1'b0, 16'h0400);
    tick();

    // Single requester: 0x1111..0x4444, ready 3 cycles after tx_req.
    bus.rq_req = 2'b01;
    run_tlp(0, 4, 3, 0, 1'b0, 16'h0000);
    tick();

    // Timeout: tx_rdy never arrives.
    bus.rq_req = 2'b01;
    wait_gnt(ok);
    bus.rq_req = 2'b00;
    if (ok) begin
      for (int k = 1; k <= TMO; k++) begin
        @(negedge clk);
        chk("err_timeout", 32'(bus.err_timeout), 32'(k == TMO));
        tick();
      end
      chk("timeout_gnt", 32'(bus.rq_gnt), 32'd0);
      chk("timeout_req", 32'(bus.tx_req_vc0), 32'd0);
    end
    tick();

    // Overlength: end marker only on word 10, cut at word MAXW.
    ovl_cnt = 0;
    bus.rq_req = 2'b01;
    run_tlp(0, 10, 1, 0, 1'b0, 16'h2000);
    tick();
    chk("overlen_pulses", 32'(ovl_cnt), 32'd1);

    // Link drop on word 2 of a 5-word TLP, then no grants while down.
    bus.rq_req = 2'b01;
    run_tlp(0, 5, 1, 2, 1'b0, 16'h5000);
    bus.rq_req = 2'b01;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("no_gnt_link_down", 32'(bus.rq_gnt), 32'd0);
    end
    bus.rq_req = 2'b00;
    bus.dl_up = 1'b1;
    tick();

    // Reset mid-XFER on word 2.
    bus.rq_req = 2'b01;
    wait_gnt(ok);
    bus.rq_req = 2'b00;
    if (ok) begin
      bus.tx_rdy_vc0 = 1'b1;
      tick();
      exp_q.push_back(pkt(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h7111));
      drive_word(0, 16'h7111, 1'b0);
      tick();
      drive_word(0, 16'h7222, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      chk("rstx_strb",  32'({bus.tx_st_vc0, bus.tx_end_vc0, bus.tx_nlfy_vc0}), 32'd0);
      chk("rstx_req",   32'(bus.tx_req_vc0), 32'd0);
      chk("rstx_gnt",   32'(bus.rq_gnt), 32'd0);
      chk("rstx_ready", 32'(bus.rq_ready), 32'd0);
      chk("rstx_data",  32'(bus.tx_data_vc0), 32'd0);
      bus.rq_valid = 2'b00;
      bus.tx_rdy_vc0 = 1'b0;
      tick();
      rst = 1'b0;
    end
    tick();

    // After reset, requester 0 wins the tie again.
    bus.rq_req = 2'b11;
    run_tlp(0, 1, 0, 0, 1'b1, 16'h8000);
    run_tlp(1, 3, 2, 0, 1'b0, 16'h9000);
    repeat (3) tick();

    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
